noc_output_arbiter: RTL and testbench

Per-output-port switch allocator that sits directly downstream of the five LBDR routing units of a router. It collects the port-request bit each input's LBDR raises for this output and grants the output to one input with round-robin fairness. The grant is held for a whole packet, from HEADER to TAIL, and flits are released only while the downstream input buffer has credits. One instance exists per output port (N, E, W, S, L), and its grant drives the crossbar select.

---
 rtl/noc_pkg.sv | 26 ++
 rtl/noc_output_arbiter_rr_pick.sv | 35 +++
 rtl/noc_output_arbiter.sv | 119 +++++++++++
 tb/tb_noc_output_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: flit type encoding, input port indices and
// the output arbiter state type.
// Imported by noc_output_arbiter, rr_pick and any allocator that needs them.
package noc_pkg;

  // Flit type field as decoded by the LBDR units (one-hot).
  localparam logic [2:0] FLIT_HEADER  = 3'b001;
  localparam logic [2:0] FLIT_PAYLOAD = 3'b010;
  localparam logic [2:0] FLIT_TAIL    = 3'b100;

  // Requesting input indices.
  localparam int P_L = 0;
  localparam int P_N = 1;
  localparam int P_E = 2;
  localparam int P_W = 3;
  localparam int P_S = 4;

  // Width of a binary input index (crossbar select, round-robin pointer).
  localparam int IDX_W = 3;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/noc_output_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner select.
// Ports: req_i (request vector), ptr_i (highest-priority index) ->
//        win_oh_o (one-hot winner), win_idx_o (binary winner), win_vld_o (any request).
module rr_pick
  import noc_pkg::*;
#(
  parameter int NIN = 5
) (
  input  logic [NIN-1:0]   req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NIN-1:0]   win_oh_o,
  output logic [IDX_W-1:0] win_idx_o,
  output logic             win_vld_o
);

  // Scan NIN positions starting at ptr_i, wrapping once; the first set
  // request wins. ptr_i is always < NIN, so one subtraction wraps.
  always_comb begin
    int idx;
    win_oh_o  = '0;
    win_idx_o = '0;
    win_vld_o = 1'b0;
    idx       = 0;
    for (int off = 0; off < NIN; off++) begin
      idx = int'(ptr_i) + off;
      if (idx >= NIN) idx = idx - NIN;
      if (!win_vld_o && req_i[idx]) begin
        win_vld_o     = 1'b1;
        win_oh_o[idx] = 1'b1;
        win_idx_o     = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter: per-output switch allocator with packet-long round-robin
// grant and credit-based flow control toward the downstream input buffer.
// Ports: clk/rst (sync, active-high); req, in_valid, flit_id from the inputs;
//        credit_in from downstream; grant/xbar_sel (registered), rd_en/valid_out
//        (combinational pop), credit_err (sticky overflow flag).
module noc_output_arbiter
  import noc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NIN   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NIN-1:0]   req,
  input  logic [NIN-1:0]   in_valid,
  input  logic [3*NIN-1:0] flit_id,
  input  logic             credit_in,
  output logic [NIN-1:0]   grant,
  output logic [2:0]       xbar_sel,
  output logic [NIN-1:0]   rd_en,
  output logic             valid_out,
  output logic             credit_err
);

  localparam int CW = $clog2(DEPTH + 1);

  arb_state_e       state_q;
  logic [NIN-1:0]   grant_q;
  logic [IDX_W-1:0] sel_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_nxt;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [NIN-1:0]   win_oh;
  logic [IDX_W-1:0] win_idx;
  logic             win_vld;

  logic [2:0]       head_type;
  logic             xfer;
  logic             xfer_tail;

  rr_pick #(.NIN(NIN)) u_pick (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx),
    .win_vld_o (win_vld)
  );

  // Flit type at the head of the granted input (grant_q is one-hot or zero).
  always_comb begin
    head_type = '0;
    for (int i = 0; i < NIN; i++) begin
      if (grant_q[i]) head_type = flit_id[3*i +: 3];
    end
  end

  assign xfer      = (state_q == ARB_BUSY) && |(grant_q & in_valid) && (cnt_q != '0);
  assign xfer_tail = xfer && (head_type == FLIT_TAIL);
  assign ptr_nxt   = (sel_q == IDX_W'(NIN - 1)) ? '0 : sel_q + IDX_W'(1);

  // A transfer and a returned credit in the same cycle cancel out. A credit
  // arriving with the counter already full is dropped and flagged.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (xfer && !credit_in) begin
      cnt_d = cnt_q - CW'(1);
    end else if (!xfer && credit_in) begin
      if (cnt_q == CW'(DEPTH)) err_d = 1'b1;
      else                     cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= CW'(DEPTH);
      err_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      case (state_q)
        ARB_IDLE: begin
          if (win_vld) begin
            state_q <= ARB_BUSY;
            grant_q <= win_oh;
            sel_q   <= win_idx;
          end
        end
        ARB_BUSY: begin
          // Ownership ends only when the TAIL flit actually crosses.
          if (xfer_tail) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= ptr_nxt;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
          grant_q <= '0;
          sel_q   <= '0;
        end
      endcase
    end
  end

  assign grant      = grant_q;
  assign xbar_sel   = 3'(sel_q);
  assign rd_en      = xfer ? grant_q : '0;
  assign valid_out  = xfer;
  assign credit_err = err_q;

endmodule

// File: tb/tb_noc_output_arbiter.sv
module tb_noc_output_arbiter;
  import noc_pkg::*;

  localparam int NIN   = 5;
  localparam int DEPTH = 4;

  typedef logic [2:0] flit_q_t[$];

  logic             clk = 1'b0;
  logic             rst;
  logic [NIN-1:0]   req;
  logic [NIN-1:0]   in_valid;
  logic [3*NIN-1:0] flit_id;
  logic             credit_in;
  logic [NIN-1:0]   grant;
  logic [2:0]       xbar_sel;
  logic [NIN-1:0]   rd_en;
  logic             valid_out;
  logic             credit_err;

  noc_output_arbiter #(.DEPTH(DEPTH), .NIN(NIN)) dut (
    .clk(clk), .rst(rst), .req(req), .in_valid(in_valid), .flit_id(flit_id),
    .credit_in(credit_in), .grant(grant), .xbar_sel(xbar_sel), .rd_en(rd_en),
    .valid_out(valid_out), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the output, next-priority input, credits left.
  int           m_owner = -1;
  int           m_ptr   = 0;
  int           m_cred  = DEPTH;
  bit           m_err   = 1'b0;
  flit_q_t      fq [NIN];
  logic [NIN-1:0] hold;
  bit           auto_credit;

  logic [NIN-1:0] obs_grant, obs_rd;
  logic [2:0]     obs_sel;
  logic           obs_vo, obs_err;
  logic [14:0]    obs_v, exp_v;
  bit             step_xfer, step_tail;
  int             ntests = 0;
  int             nfail  = 0;

  task automatic push_pkt(input int i, input int len);
    fq[i].push_back(FLIT_HEADER);
    for (int k = 0; k < len - 2; k++) fq[i].push_back(FLIT_PAYLOAD);
    fq[i].push_back(FLIT_TAIL);
  endtask

  task automatic clear_queues();
    for (int i = 0; i < NIN; i++) fq[i].delete();
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < NIN; i++) begin
      req[i]           = fq[i].size() > 0;
      in_valid[i]      = (fq[i].size() > 0) && !hold[i];
      flit_id[3*i +: 3] = (fq[i].size() > 0) ? fq[i][0] : 3'b000;
    end
  endtask

  // One clock cycle: drive inputs, capture outputs and model expectations,
  // then advance the model across the rising edge.
  task automatic step();
    logic [NIN-1:0] eg, er;
    logic [2:0]     es, head;
    bit             x;
    int             j;
    apply_inputs();
    #1;
    x    = (m_owner >= 0) && (fq[m_owner].size() > 0) && !hold[m_owner] && (m_cred > 0);
    head = x ? fq[m_owner][0] : 3'b000;
    eg   = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    es   = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
    er   = x ? eg : '0;
    if (auto_credit) credit_in = x;
    exp_v     = {eg, es, er, x, m_err};
    obs_grant = grant; obs_sel = xbar_sel; obs_rd = rd_en;
    obs_vo    = valid_out; obs_err = credit_err;
    obs_v     = {obs_grant, obs_sel, obs_rd, obs_vo, obs_err};
    step_xfer = x;
    step_tail = x && (head == FLIT_TAIL);
    @(posedge clk);
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_cred = DEPTH; m_err = 1'b0;
    end else begin
      if (x) void'(fq[m_owner].pop_front());
      if (x && !credit_in) m_cred--;
      else if (!x && credit_in) begin
        if (m_cred == DEPTH) m_err = 1'b1;
        else                 m_cred++;
      end
      if (m_owner < 0) begin
        for (int k = 0; k < NIN; k++) begin
          j = (m_ptr + k) % NIN;
          if (req[j]) begin
            m_owner = j;
            break;
          end
        end
      end else if (step_tail) begin
        m_ptr   = (m_owner + 1) % NIN;
        m_owner = -1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_queues();
    hold = '0; credit_in = 1'b0; auto_credit = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  function automatic int oh2idx(input logic [NIN-1:0] oh);
    int r;
    r = -1;
    for (int i = 0; i < NIN; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic test_reset();
    clear_queues();
    hold = '0; credit_in = 1'b0; auto_credit = 1'b0;
    rst = 1'b1;
    step();
    step();
    ntests++;
    if (obs_v !== 15'd0) begin
      nfail++; $display("FAIL reset_outputs: got %h expected %h", obs_v, 15'd0);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_packet();
    int nv, first_g;
    do_reset();
    push_pkt(P_E, 4);
    nv = 0; first_g = -1;
    for (int c = 0; c < 10; c++) begin
      step();
      ntests++;
      if (obs_v !== exp_v) begin
        nfail++; $display("FAIL single_cycle%0d: got %h expected %h", c, obs_v, exp_v);
      end
      if (obs_vo) nv++;
      if (first_g < 0 && obs_grant != '0) first_g = c;
      if (c == 1) begin
        ntests++;
        if (obs_grant !== 5'b00100 || obs_sel !== 3'd2) begin
          nfail++; $display("FAIL single_grant: got %b/%0d expected 00100/2", obs_grant, obs_sel);
        end
      end
    end
    ntests++;
    if (nv != 4 || first_g != 1) begin
      nfail++; $display("FAIL single_count: got %0d pulses grant@%0d expected 4 grant@1", nv, first_g);
    end
    // Everyone now requests: pointer 3 must win, and zero credits block the HEADER.
    for (int i = 0; i < NIN; i++) push_pkt(i, 2);
    step();
    step();
    ntests++;
    if (obs_grant !== 5'b01000 || obs_vo !== 1'b0) begin
      nfail++; $display("FAIL single_ptr_cred: got grant %b vo %b expected 01000 0", obs_grant, obs_vo);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int zrun, seen_one;
    logic [NIN-1:0] prev_g;
    do_reset();
    for (int r = 0; r < 2; r++) for (int i = 0; i < NIN; i++) push_pkt(i, 2);
    auto_credit = 1'b1;
    prev_g = '0; zrun = 0; seen_one = 0;
    for (int c = 0; c < 32; c++) begin
      step();
      ntests++;
      if (obs_v !== exp_v) begin
        nfail++; $display("FAIL rr_cycle%0d: got %h expected %h", c, obs_v, exp_v);
      end
      if (prev_g == '0 && obs_grant != '0) order.push_back(oh2idx(obs_grant));
      prev_g = obs_grant;
      if (obs_vo) begin
        if (seen_one != 0 && zrun != 0) begin
          ntests++;
          if (zrun != 1) begin
            nfail++; $display("FAIL rr_bubble: got %0d idle cycles expected 1", zrun);
          end
        end
        seen_one = 1; zrun = 0;
      end else if (seen_one != 0) zrun++;
    end
    auto_credit = 1'b0; credit_in = 1'b0;
    ntests++;
    if (order.size() < 6) begin
      nfail++; $display("FAIL rr_order: got %0d grants expected at least 6", order.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        ntests++;
        if (order[k] != (k % NIN)) begin
          nfail++; $display("FAIL rr_order%0d: got %0d expected %0d", k, order[k], k % NIN);
        end
      end
    end
  endtask

  task automatic test_packet_hold();
    int tail_c;
    do_reset();
    push_pkt(P_N, 4);
    step();
    step();
    push_pkt(P_L, 2);
    tail_c = -1;
    for (int k = 0; k < 10; k++) begin
      step();
      ntests++;
      if (obs_v !== exp_v) begin
        nfail++; $display("FAIL hold_cycle%0d: got %h expected %h", k, obs_v, exp_v);
      end
      if (tail_c < 0) begin
        ntests++;
        if (obs_grant !== 5'b00010) begin
          nfail++; $display("FAIL hold_grant: got %b expected 00010", obs_grant);
        end
        if (step_tail) tail_c = k;
      end else if (k == tail_c + 1) begin
        ntests++;
        if (obs_grant !== 5'b00000) begin
          nfail++; $display("FAIL hold_idle: got %b expected 00000", obs_grant);
        end
      end else if (k == tail_c + 2) begin
        ntests++;
        if (obs_grant !== 5'b00001) begin
          nfail++; $display("FAIL hold_next: got %b expected 00001", obs_grant);
        end
      end
    end
    ntests++;
    if (tail_c < 0) begin
      nfail++; $display("FAIL hold_timeout: got no TAIL transfer expected one within 10 cycles");
    end
  endtask

  task automatic test_credit_stall();
    logic [15:0] vo_pat;
    vo_pat = 16'h291E;  // transfers in cycles 1-4, 8, 11, 13
    do_reset();
    push_pkt(P_L, 6);
    push_pkt(P_L, 2);
    for (int c = 0; c < 16; c++) begin
      credit_in = (c == 7) || (c == 10) || (c == 11);
      step();
      ntests++;
      if (obs_v !== exp_v) begin
        nfail++; $display("FAIL stall_cycle%0d: got %h expected %h", c, obs_v, exp_v);
      end
      ntests++;
      if (obs_vo !== vo_pat[c]) begin
        nfail++; $display("FAIL stall_vo%0d: got %b expected %b", c, obs_vo, vo_pat[c]);
      end
      if (c >= 5 && c <= 7) begin
        ntests++;
        if (obs_grant !== 5'b00001) begin
          nfail++; $display("FAIL stall_busy%0d: got %b expected 00001", c, obs_grant);
        end
      end
    end
    credit_in = 1'b0;
  endtask

  task automatic test_overflow_reset();
    int nv;
    do_reset();
    credit_in = 1'b1;
    step();
    credit_in = 1'b0;
    step();
    ntests++;
    if (obs_err !== 1'b1) begin
      nfail++; $display("FAIL ovf_err: got %b expected 1", obs_err);
    end
    push_pkt(P_E, 4);
    step();
    step();
    step();
    clear_queues();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    ntests++;
    if (obs_grant !== '0 || obs_err !== 1'b0 || obs_v !== exp_v) begin
      nfail++; $display("FAIL rst_mid: got grant %b err %b expected 00000 0", obs_grant, obs_err);
    end
    push_pkt(P_S, 4);
    push_pkt(P_L, 4);
    step();
    step();
    ntests++;
    if (obs_grant !== 5'b00001) begin
      nfail++; $display("FAIL rst_ptr: got %b expected 00001", obs_grant);
    end
    nv = obs_vo ? 1 : 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (obs_vo) nv++;
    end
    ntests++;
    if (nv != 4) begin
      nfail++; $display("FAIL rst_credit: got %0d transfers expected 4", nv);
    end
  endtask

  task automatic test_random();
    int i;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        i = $urandom_range(0, NIN - 1);
        if (fq[i].size() < 10) push_pkt(i, $urandom_range(2, 5));
      end
      for (int k = 0; k < NIN; k++) hold[k] = ($urandom_range(0, 3) == 0);
      credit_in = ((m_cred < DEPTH) && ($urandom_range(0, 1) == 1)) || ($urandom_range(0, 49) == 0);
      step();
      ntests++;
      if (obs_v !== exp_v) begin
        nfail++; $display("FAIL rand_cycle%0d: got %h expected %h", c, obs_v, exp_v);
      end
    end
    hold = '0; credit_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1; credit_in = 1'b0; hold = '0; auto_credit = 1'b0;
    req = '0; in_valid = '0; flit_id = '0;
    @(negedge clk);
    test_reset();
    test_single_packet();
    test_round_robin();
    test_packet_hold();
    test_credit_stall();
    test_overflow_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
